// File: rtl/circuito_somador_if.sv
// Purpose: bundles the operand, chain and result signals of one adder/subtractor slice.
// Latency: none of its own; R/Cout/COMPLEMENTOout are combinational, R_reg/Cout_reg are one clk later.
// Backpressure: none; the slice accepts new operands every cycle and is always ready.
//
// Ports (by modport):
//   master - drives A, B, Cin, COMPLEMENTOin, select; observes all results
//   slave  - the slice itself: consumes operands and chain inputs, drives results
interface circuito_somador_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             COMPLEMENTOin;
    logic             select;
    logic [WIDTH-1:0] R;
    logic             Cout;
    logic             COMPLEMENTOout;
    logic [WIDTH-1:0] R_reg;
    logic             Cout_reg;

    modport master (
        output A, B, Cin, COMPLEMENTOin, select,
        input  R, Cout, COMPLEMENTOout, R_reg, Cout_reg
    );

    modport slave (
        input  A, B, Cin, COMPLEMENTOin, select,
        output R, Cout, COMPLEMENTOout, R_reg, Cout_reg
    );
endinterface

// File: rtl/circuito_somador.sv
// Purpose: chainable WIDTH-bit two's-complement add (select=0) / subtract (select=1) slice.
// Latency: R/Cout/COMPLEMENTOout are zero-latency combinational; R_reg/Cout_reg lag by one clk.
// Backpressure: none; operands are consumed continuously, results are always valid.
//
// Ports:
//   clk   - rising-edge clock, used only by the registered copies
//   rst_n - asynchronous active-low reset, clears R_reg/Cout_reg only
//   bus   - slave side of circuito_somador_if (operands, chain in/out, results)
module circuito_somador #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    circuito_somador_if.slave  bus
);

    // Negation chain: when subtracting, B is replaced by ~B + COMPLEMENTOin.
    // Per bit that is bx[i] = ~B[i] ^ c[i], c[i+1] = ~B[i] & c[i], which is
    // exactly an incrementer, so it is written as one. Across chained slices
    // COMPLEMENTOin is only 1 while every lower B bit was 0, which makes the
    // whole chain compute ~B + 1. When adding, B passes through and the chain
    // out is 0 so upper slices never increment.
    logic [WIDTH:0]   neg_sum;
    logic [WIDTH-1:0] bx;
    logic             c_out;

    // Ripple carry: r[i] = A^bx^k, k[i+1] = maj(A, bx, k), i.e. a plain adder
    // with Cin as the incoming carry.
    logic [WIDTH:0]   add_sum;

    always_comb begin
        neg_sum = {1'b0, ~bus.B} + {{WIDTH{1'b0}}, bus.COMPLEMENTOin};
        if (bus.select) begin
            bx    = neg_sum[WIDTH-1:0];
            c_out = neg_sum[WIDTH];
        end else begin
            bx    = bus.B;
            c_out = 1'b0;
        end
        add_sum = {1'b0, bus.A} + {1'b0, bx} + {{WIDTH{1'b0}}, bus.Cin};
    end

    assign bus.R              = add_sum[WIDTH-1:0];
    assign bus.Cout           = add_sum[WIDTH];
    assign bus.COMPLEMENTOout = c_out;

    // Registered copy for the pipelined ULA output. Reset only clears these;
    // the combinational path keeps tracking the inputs while rst_n is low.
    logic [WIDTH-1:0] r_q;
    logic             cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            r_q    <= add_sum[WIDTH-1:0];
            cout_q <= add_sum[WIDTH];
        end
    end

    assign bus.R_reg    = r_q;
    assign bus.Cout_reg = cout_q;

endmodule

// File: tb/tb_circuito_somador.sv
// Purpose: checks a 3-slice WIDTH=1 chain of circuito_somador against a 3-bit arithmetic model.
// Latency: combinational results checked 1 time unit after drive; registered ones 1 unit after clk.
// Backpressure: none; stimulus is applied open-loop.
module tb_circuito_somador;

    logic clk;
    logic rst_n;

    circuito_somador_if #(.WIDTH(1)) if0 ();
    circuito_somador_if #(.WIDTH(1)) if1 ();
    circuito_somador_if #(.WIDTH(1)) if2 ();

    circuito_somador #(.WIDTH(1)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    circuito_somador #(.WIDTH(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    circuito_somador #(.WIDTH(1)) u_s2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    // Cascade: carry and negation chains ripple slice to slice.
    assign if1.Cin           = if0.Cout;
    assign if1.COMPLEMENTOin = if0.COMPLEMENTOout;
    assign if2.Cin           = if1.Cout;
    assign if2.COMPLEMENTOin = if1.COMPLEMENTOout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] r;
        logic       cout;
        logic       cmp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic [2:0] r_bus;
    logic [2:0] r_reg_bus;
    assign r_bus     = {if2.R, if1.R, if0.R};
    assign r_reg_bus = {if2.R_reg, if1.R_reg, if0.R_reg};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive operands on all slices and push the 3-bit model result.
    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic sel);
        exp_t       e;
        logic [2:0] nb;
        logic [3:0] sum;
        if0.A = a[0]; if1.A = a[1]; if2.A = a[2];
        if0.B = b[0]; if1.B = b[1]; if2.B = b[2];
        if0.select = sel; if1.select = sel; if2.select = sel;
        nb     = sel ? (~b + 3'd1) : b;
        sum    = {1'b0, a} + {1'b0, nb};
        e.r    = sum[2:0];
        e.cout = sum[3];
        e.cmp  = sel && (b == 3'd0);
        sb.push_back(e);
    endtask

    task automatic compare_comb(input string tag);
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_R"}, {5'd0, r_bus}, {5'd0, e.r});
            check({tag, "_Cout"}, {7'd0, if2.Cout}, {7'd0, e.cout});
            check({tag, "_COMPout"}, {7'd0, if2.COMPLEMENTOout}, {7'd0, e.cmp});
        end
    endtask

    task automatic check_reg(input string tag, input logic [2:0] er, input logic ec);
        check({tag, "_R_reg"}, {5'd0, r_reg_bus}, {5'd0, er});
        check({tag, "_Cout_reg"}, {7'd0, if2.Cout_reg}, {7'd0, ec});
    endtask

    initial begin
        rst_n = 1'b0;
        if0.Cin = 1'b0;
        if0.COMPLEMENTOin = 1'b1;
        drive(3'd0, 3'd0, 1'b0);
        #2;
        check_reg("reset_init", 3'd0, 1'b0);
        compare_comb("comb_in_reset");

        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        drive(3'd3, 3'd1, 1'b0); compare_comb("add_3p1_wrap");
        drive(3'd2, 3'd5, 1'b0); compare_comb("add_2pm3");
        drive(3'd2, 3'd3, 1'b1); compare_comb("sub_2m3");
        drive(3'd4, 3'd4, 1'b1); compare_comb("sub_m4mm4");
        drive(3'd4, 3'd1, 1'b1); compare_comb("sub_m4m1_wrap");
        drive(3'd3, 3'd0, 1'b1); compare_comb("sub_by_0");

        // Exhaustive sweep, 10 time units per vector
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    drive(a[2:0], b[2:0], s[0]);
                    compare_comb("exh");
                    #9;
                end
            end
        end

        // Registered path
        @(negedge clk);
        drive(3'd1, 3'd1, 1'b0); compare_comb("reg_1p1_comb");
        @(posedge clk); #1;
        check_reg("reg_1p1", 3'd2, 1'b0);

        @(negedge clk);
        drive(3'd4, 3'd1, 1'b1); compare_comb("reg_m4m1_comb");
        @(posedge clk); #1;
        check_reg("reg_m4m1", 3'd3, 1'b1);

        // Mid-run reset clears registers at once, comb keeps tracking
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reg("reset_mid", 3'd0, 1'b0);
        drive(3'd1, 3'd1, 1'b0); compare_comb("comb_track_in_reset");
        @(posedge clk); #1;
        check_reg("reset_held", 3'd0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reg("release_no_capture", 3'd0, 1'b0);
        @(posedge clk); #1;
        check_reg("first_capture", 3'd2, 1'b0);

        check("sb_drained", 8'(sb.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
